// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_ctrl
// Description : 4x3 matrix keypad scanner. Drives one row low per slot,
//               samples the active-low column lines at the end of each slot,
//               and folds four row samples into one frame result (none,
//               single key, multiple keys). A debounce FSM accepts a press
//               after DEBOUNCE_SCANS identical single-key frames and a
//               release after the same number of empty frames. Each accepted
//               press is pushed into a 4-entry FIFO read with valid/ready.
// Ports       : CLOCK_50    - system clock, rising edge
//               reset       - asynchronous active-high reset
//               cols[2:0]   - column lines, active-low
//               rows[3:0]   - row drive, one-cold, active-low
//               key_code    - head-of-queue key code 0..11 (0 when empty)
//               key_valid   - queue not empty
//               key_ready   - consumer accepts key_code
//               key_pressed - debounced key-held level
//               overflow    - sticky: a key event was dropped on a full queue
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_pressed,
    output logic       overflow
);

    localparam int              c_CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CW-1:0] c_SLOT_LAST = c_CW'(SCAN_DIV - 1);
    localparam logic [3:0]      c_DEB       = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    // ------------------------------------------------------------------ scan
    logic [c_CW-1:0] slot_q;
    logic [1:0]      idx_q;
    logic            tick;
    logic            frame_end;

    assign tick      = (slot_q == c_SLOT_LAST);
    assign frame_end = tick && (idx_q == 2'd3);
    assign rows      = ~(4'b0001 << idx_q);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
            idx_q  <= 2'd0;
        end else if (tick) begin
            slot_q <= '0;
            idx_q  <= idx_q + 2'd1;
        end else begin
            slot_q <= slot_q + 1'b1;
        end
    end

    // ---------------------------------------------------------- row decode
    logic       samp_single;
    logic       samp_multi;
    logic [1:0] samp_col;
    logic [3:0] samp_code;

    always_comb begin
        samp_single = 1'b0;
        samp_multi  = 1'b0;
        samp_col    = 2'd0;
        case (cols)
            3'b110:  begin samp_single = 1'b1; samp_col = 2'd0; end
            3'b101:  begin samp_single = 1'b1; samp_col = 2'd1; end
            3'b011:  begin samp_single = 1'b1; samp_col = 2'd2; end
            3'b111:  ;
            default: samp_multi = 1'b1;
        endcase
    end

    assign samp_code = ({2'b00, idx_q} * 4'd3) + {2'b00, samp_col};

    // ------------------------------------------------- frame accumulation
    // Rows 0..2 are accumulated in registers; the row-3 sample is merged
    // combinationally so the frame result is available on the row-3 tick.
    logic       found_q;
    logic       multi_q;
    logic [3:0] fcode_q;
    logic       frm_multi;
    logic       frm_single;
    logic       frm_none;
    logic [3:0] frm_code;

    // A single sample after an earlier row already held a key means keys
    // in two rows, which is a multi-key frame.
    assign frm_multi  = multi_q | samp_multi | (found_q & samp_single);
    assign frm_single = ~frm_multi & (found_q | samp_single);
    assign frm_none   = ~frm_multi & ~frm_single;
    assign frm_code   = found_q ? fcode_q : samp_code;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            found_q <= 1'b0;
            multi_q <= 1'b0;
            fcode_q <= 4'd0;
        end else if (tick) begin
            if (idx_q == 2'd3) begin
                found_q <= 1'b0;
                multi_q <= 1'b0;
                fcode_q <= 4'd0;
            end else begin
                multi_q <= frm_multi;
                if (samp_single && !found_q) begin
                    found_q <= 1'b1;
                    fcode_q <= samp_code;
                end
            end
        end
    end

    // -------------------------------------------------------- debounce FSM
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cand_q, cand_d;
    logic       pressed_q, pressed_d;
    logic       push;
    logic [3:0] cnt_inc;

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        pressed_d = pressed_q;
        push      = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frm_single) begin
                        cand_d = frm_code;
                        cnt_d  = 4'd1;
                        if (c_DEB == 4'd1) begin
                            state_d   = HELD;
                            push      = 1'b1;
                            pressed_d = 1'b1;
                        end else begin
                            state_d = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (frm_single && (frm_code == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == c_DEB) begin
                            state_d   = HELD;
                            push      = 1'b1;
                            pressed_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (frm_none) begin
                        cnt_d = 4'd1;
                        if (c_DEB == 4'd1) begin
                            state_d   = IDLE;
                            pressed_d = 1'b0;
                        end else begin
                            state_d = REL_CHK;
                        end
                    end
                end
                REL_CHK: begin
                    if (frm_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == c_DEB) begin
                            state_d   = IDLE;
                            pressed_d = 1'b0;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cand_q    <= 4'd0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            pressed_q <= pressed_d;
        end
    end

    assign key_pressed = pressed_q;

    // ---------------------------------------------------------------- FIFO
    logic [3:0] mem_q [4];
    logic [1:0] wr_q;
    logic [1:0] rd_q;
    logic [2:0] count_q;
    logic       ovf_q;
    logic       full;
    logic       pop;
    logic       push_ok;

    assign key_valid = (count_q != 3'd0);
    assign full      = (count_q == 3'd4);
    assign pop       = key_valid & key_ready;
    // A simultaneous pop frees the slot, so a push into a full queue is
    // still accepted in that cycle.
    assign push_ok   = push & (~full | pop);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_q    <= 2'd0;
            rd_q    <= 2'd0;
            count_q <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + 2'd1;
            if (pop)     rd_q <= rd_q + 2'd1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    // Storage needs no reset: key_code is forced to 0 whenever the queue
    // is empty, so stale entries are never visible.
    always_ff @(posedge CLOCK_50) begin
        if (push_ok) mem_q[wr_q] <= cand_d;
    end

    assign key_code = key_valid ? mem_q[rd_q] : 4'd0;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_ctrl
// Description : Self-checking bench for keypad_scan_ctrl (SCAN_DIV=4,
//               DEBOUNCE_SCANS=3, 16-cycle frames). A keypad model turns a
//               12-bit set of held keys into column levels. A frame-level
//               reference model predicts accepted presses into an expected
//               queue; a monitor compares every cycle and pops on handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam int SD    = 4;
    localparam int DS    = 3;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cols;
    logic [3:0] rows;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_pressed;
    logic       overflow;
    logic [11:0] keys;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .cols       (cols),
        .rows       (rows),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_pressed(key_pressed),
        .overflow   (overflow)
    );

    // Physical keypad: a held key in a driven (low) row pulls its column low.
    always_comb begin
        cols = 3'b111;
        for (int r = 0; r < 4; r++)
            if (!rows[r]) cols = cols & ~keys[r*3 +: 3];
    end

    // ------------------------------------------------------ reference model
    int  exp_q[$];
    bit  m_held;
    int  m_run;
    int  m_cand;
    int  m_rel;
    bit  exp_pressed;
    bit  exp_ovf;
    int  cyc;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic accept_press();
        m_held      = 1'b1;
        m_run       = 0;
        m_rel       = 0;
        exp_pressed = 1'b1;
        if (exp_q.size() < 4) exp_q.push_back(m_cand);
        else                  exp_ovf = 1'b1;
    endtask

    // One frame: the held-key set is constant over the frame, so the frame
    // result is simply how many keys are down (0 none, 1 single, 2+ multi).
    task automatic model_frame();
        int n;
        int k;
        n = $countones(keys);
        k = 0;
        for (int i = 0; i < 12; i++) if (keys[i]) k = i;
        if (!m_held) begin
            if (m_run > 0) begin
                if (n == 1 && k == m_cand) begin
                    m_run++;
                    if (m_run == DS) accept_press();
                end else begin
                    m_run = 0;
                end
            end else if (n == 1) begin
                m_cand = k;
                m_run  = 1;
            end
        end else begin
            if (n == 0) begin
                m_rel++;
                if (m_rel == DS) begin
                    m_held      = 1'b0;
                    m_rel       = 0;
                    exp_pressed = 1'b0;
                end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_held      = 1'b0;
            m_run       = 0;
            m_cand      = 0;
            m_rel       = 0;
            exp_pressed = 1'b0;
            exp_ovf     = 1'b0;
            cyc         = 0;
        end else begin
            cyc++;
            if (cyc % FRAME == 0) model_frame();
        end
    end

    // -------------------------------------------------------------- monitor
    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] er;
        if (rst) begin
            chk("rst_rows",    rows, 4'hE);
            chk("rst_code",    key_code, 0);
            chk("rst_valid",   key_valid, 0);
            chk("rst_pressed", key_pressed, 0);
            chk("rst_ovf",     overflow, 0);
        end else begin
            er = ~(4'b0001 << ((cyc / SD) % 4));
            chk("rows",    rows, er);
            chk("valid",   key_valid, (exp_q.size() != 0) ? 1 : 0);
            if (exp_q.size() != 0) chk("code", key_code, exp_q[0]);
            else                   chk("code_empty", key_code, 0);
            chk("pressed", key_pressed, exp_pressed);
            chk("ovf",     overflow, exp_ovf);
            if (key_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic frames(input int n);
        repeat (n * FRAME) @(posedge clk);
        #1;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
        while (cyc % FRAME != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic press_release(input int k);
        keys = 12'(1 << k);
        frames(DS);
        keys = '0;
        frames(DS);
    endtask

    task automatic drain(input int n);
        key_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        key_ready = 1'b0;
        align();
    endtask

    initial begin
        int a, b;
        rst       = 1'b1;
        keys      = '0;
        key_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // key 5 held, consumer stalled, then a one-cycle read
        keys = 12'(1 << 5);
        frames(3);
        frames(10);
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        key_ready = 1'b0;
        align();
        keys = '0;
        frames(4);

        // key 7 too short to be accepted
        keys = 12'(1 << 7);
        frames(2);
        keys = '0;
        frames(3);

        // keys 0 and 4 together: multi every frame
        keys = 12'((1 << 0) | (1 << 4));
        frames(5);
        keys = '0;
        frames(2);

        // five presses into a 4-deep queue, then drain
        press_release(1);
        press_release(2);
        press_release(3);
        press_release(4);
        press_release(6);
        drain(6);

        // full queue with a pop in the exact push cycle of key 9
        do_reset(2);
        press_release(1);
        press_release(2);
        press_release(3);
        press_release(4);
        keys = 12'(1 << 9);
        frames(2);
        repeat (FRAME - 1) @(posedge clk);
        #1;
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        key_ready = 1'b0;
        keys = '0;
        frames(3);
        drain(6);

        // reset while held with two entries queued; key stays down
        press_release(8);
        keys = 12'(1 << 10);
        frames(4);
        do_reset(3);
        frames(4);
        keys = '0;
        frames(3);
        drain(4);

        // randomized keys per frame and random consumer
        do_reset(2);
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 9) < 4) begin
                case ($urandom_range(0, 19))
                    0, 1, 2, 3, 4, 5, 6, 7: keys = '0;
                    8, 9, 10, 11, 12, 13, 14, 15, 16:
                        keys = 12'(1 << $urandom_range(0, 11));
                    default: begin
                        a = $urandom_range(0, 11);
                        b = $urandom_range(0, 11);
                        keys = 12'((1 << a) | (1 << b));
                    end
                endcase
            end
            for (int c = 0; c < FRAME; c++) begin
                key_ready = ($urandom_range(0, 3) == 0);
                @(posedge clk);
                #1;
            end
        end
        key_ready = 1'b0;
        keys = '0;
        frames(4);
        drain(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
